// File: rtl/imem_loader.sv
// imem_loader: streams 16-bit instruction words into a byte-wide instruction memory, big-endian, holding the CPU in reset meanwhile
//   clock, reset             rising-edge clock, asynchronous active-high reset
//   start, abort             1-cycle pulses: begin a load at BASE_ADDR / cancel and return to idle
//   in_valid, in_ready       word stream handshake; in_word high byte goes to even addr A, low byte to A+1
//   in_word, in_last         instruction word and final-word flag
//   mem_wr_en/addr/data      byte write port to the instruction memory (addr/data 0 when idle)
//   cpu_hold, busy           CPU reset hold / load in progress
//   done, error              sticky: image loaded / image overflowed DEPTH
//   word_count               words written in the current or last load
module imem_loader #(
    parameter int DEPTH     = 128,
    parameter int ADDR_W    = 16,
    parameter int BASE_ADDR = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [15:0]       in_word,
    input  logic              in_last,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [7:0]        mem_wr_data,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-1:0] word_count
);
    typedef enum logic [2:0] {IDLE, WAIT_WORD, WR_HI, WR_LO, DONE, ERR} state_t;
    localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] LAST_SLOT = ADDR_W'(DEPTH - 2);
    state_t            state, state_n;
    logic [ADDR_W-1:0] addr, addr_n, count_n;
    logic [15:0]       word, word_n;
    logic              last, last_n;
    assign in_ready = state == WAIT_WORD;
    always_comb begin
        state_n = state;
        addr_n  = addr;
        count_n = word_count;
        word_n  = word;
        last_n  = last;
        if (abort && state != IDLE)
            state_n = IDLE;
        else
            case (state)
                IDLE, DONE, ERR: if (start) begin
                    state_n = WAIT_WORD;
                    addr_n  = BASE;
                    count_n = '0;
                end
                WAIT_WORD: if (in_valid) begin
                    // a word arriving with memory full is still consumed, just never written
                    word_n  = in_word;
                    last_n  = in_last;
                    state_n = addr <= LAST_SLOT ? WR_HI : ERR;
                end
                WR_HI: state_n = WR_LO;
                WR_LO: begin
                    addr_n  = addr + ADDR_W'(2);
                    count_n = word_count + ADDR_W'(1);
                    state_n = last ? DONE : WAIT_WORD;
                end
                default: state_n = IDLE;
            endcase
    end
    // outputs are registered from the next state so the high byte appears the cycle after the handshake
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            addr        <= BASE;
            word        <= '0;
            last        <= 1'b0;
            word_count  <= '0;
            mem_wr_en   <= 1'b0;
            mem_wr_addr <= '0;
            mem_wr_data <= '0;
            cpu_hold    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
        end else begin
            state       <= state_n;
            addr        <= addr_n;
            word        <= word_n;
            last        <= last_n;
            word_count  <= count_n;
            mem_wr_en   <= state_n == WR_HI || state_n == WR_LO;
            mem_wr_addr <= state_n == WR_HI ? addr : state_n == WR_LO ? addr + ADDR_W'(1) : '0;
            mem_wr_data <= state_n == WR_HI ? word_n[15:8] : state_n == WR_LO ? word_n[7:0] : '0;
            cpu_hold    <= state_n inside {WAIT_WORD, WR_HI, WR_LO};
            busy        <= state_n inside {WAIT_WORD, WR_HI, WR_LO};
            done        <= state_n == DONE;
            error       <= state_n == ERR;
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed self-checking bench for imem_loader (DEPTH=128, BASE_ADDR=0)
module tb_imem_loader;
    logic        clock = 1'b0, reset = 1'b1, start = 1'b0, abort = 1'b0;
    logic        in_valid = 1'b0, in_last = 1'b0, in_ready;
    logic [15:0] in_word = '0;
    logic        mem_wr_en, cpu_hold, busy, done, error;
    logic [15:0] mem_wr_addr, word_count;
    logic [7:0]  mem_wr_data;
    int          n_chk = 0, n_fail = 0, nwr = 0, bad = 0, base, e;
    logic [15:0] wa [1024];
    logic [7:0]  wd [1024];
    logic [15:0] t1a [6] = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5};
    logic [7:0]  t1d [6] = '{8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'hFF};

    imem_loader dut (
        .clock(clock), .reset(reset), .start(start), .abort(abort),
        .in_valid(in_valid), .in_ready(in_ready), .in_word(in_word), .in_last(in_last),
        .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .cpu_hold(cpu_hold), .busy(busy), .done(done), .error(error), .word_count(word_count)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (mem_wr_en) begin
            if (nwr < 1024) begin
                wa[nwr] = mem_wr_addr;
                wd[nwr] = mem_wr_data;
            end
            nwr++;
            if (mem_wr_addr >= 16'd128) bad++;
        end else if (mem_wr_addr !== 16'd0 || mem_wr_data !== 8'd0) bad++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
        #1;
    endtask

    task automatic pulse_start();
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    // returns at the negedge after the handshake edge, i.e. during the high-byte write cycle
    task automatic send(input logic [15:0] w, input logic l);
        int n = 0;
        @(negedge clock);
        while (!in_ready && n < 20) begin
            @(negedge clock);
            n++;
        end
        if (!in_ready) chk("in_ready_timeout", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        in_word  = w;
        in_last  = l;
        @(negedge clock);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic check_img(input string tag, input int b);
        e = 0;
        for (int k = 0; k < 6; k++)
            if (wa[b+k] !== t1a[k] || wd[b+k] !== t1d[k]) e++;
        chk(tag, e, 0);
    endtask

    initial begin
        cyc(2);
        reset = 1'b0;
        cyc(1);
        chk("rst_wr_en", {31'd0, mem_wr_en}, 0);
        chk("rst_in_ready", {31'd0, in_ready}, 0);
        chk("rst_flags", {28'd0, cpu_hold, busy, done, error}, 0);
        chk("rst_word_count", word_count, 0);

        // test 1: three words back to back, with latency checks on the first
        base = nwr;
        pulse_start();
        #1;
        chk("t1_hold_busy", {30'd0, cpu_hold, busy}, 32'h3);
        chk("t1_in_ready", {31'd0, in_ready}, 1);
        send(16'h1234, 1'b0);
        chk("t1_hi_write", {mem_wr_en, mem_wr_addr, mem_wr_data}, {1'b1, 16'd0, 8'h12});
        chk("t1_hi_backpressure", {31'd0, in_ready}, 0);
        @(negedge clock);
        chk("t1_lo_write", {mem_wr_en, mem_wr_addr, mem_wr_data}, {1'b1, 16'd1, 8'h34});
        send(16'hABCD, 1'b0);
        send(16'h00FF, 1'b1);
        chk("t1_hold_during", {31'd0, cpu_hold}, 1);
        cyc(2);
        chk("t1_done", {29'd0, done, error, cpu_hold}, 32'h4);
        chk("t1_word_count", word_count, 3);
        chk("t1_nwr", nwr - base, 6);
        check_img("t1_image", base);

        // test 2: gaps of 5 idle cycles between words
        base = nwr;
        pulse_start();
        send(16'h1234, 1'b0);
        cyc(2);
        e = 0;
        repeat (5) begin
            if (mem_wr_en !== 1'b0) e++;
            cyc(1);
        end
        send(16'hABCD, 1'b0);
        cyc(2);
        repeat (5) begin
            if (mem_wr_en !== 1'b0) e++;
            cyc(1);
        end
        chk("t2_gap_no_write", e, 0);
        send(16'h00FF, 1'b1);
        cyc(2);
        chk("t2_done", {31'd0, done}, 1);
        chk("t2_word_count", word_count, 3);
        chk("t2_nwr", nwr - base, 6);
        check_img("t2_image", base);

        // test 3: exact fill, then overflow
        base = nwr;
        pulse_start();
        for (int i = 0; i < 64; i++) send({8'(2*i), 8'(2*i+1)}, i == 63);
        cyc(2);
        chk("t3_fill_done", {30'd0, done, error}, 32'h2);
        chk("t3_fill_count", word_count, 64);
        chk("t3_fill_nwr", nwr - base, 128);
        e = 0;
        for (int k = 0; k < 128; k++)
            if (wa[base+k] !== 16'(k) || wd[base+k] !== 8'(k)) e++;
        chk("t3_fill_image", e, 0);
        chk("t3_last_addr", {wa[base+126], wa[base+127]}, {16'd126, 16'd127});
        base = nwr;
        pulse_start();
        for (int i = 0; i < 65; i++) send(16'hDEAD, 1'b0);
        cyc(2);
        chk("t3_ovf_flags", {29'd0, done, error, cpu_hold}, 32'h2);
        chk("t3_ovf_count", word_count, 64);
        chk("t3_ovf_nwr", nwr - base, 128);
        chk("t3_ovf_in_ready", {31'd0, in_ready}, 0);
        chk("t3_no_bad_write", bad, 0);

        // test 4: reset during the high-byte write of word 2
        pulse_start();
        send(16'h1111, 1'b0);
        send(16'h2222, 1'b0);
        #1;
        reset = 1'b1;
        base = nwr;
        cyc(1);
        chk("t4_rst_outputs", {mem_wr_en, in_ready, cpu_hold, busy, done, error}, 0);
        chk("t4_rst_count", word_count, 0);
        cyc(3);
        chk("t4_no_write", nwr - base, 0);
        reset = 1'b0;
        base = nwr;
        pulse_start();
        send(16'hBEEF, 1'b1);
        cyc(2);
        chk("t4_restart", {wa[base], wd[base], wa[base+1], wd[base+1]}, {16'd0, 8'hBE, 16'd1, 8'hEF});
        chk("t4_done", {31'd0, done}, 1);

        // test 5: start during WR_LO ignored, then abort in WAIT_WORD
        base = nwr;
        pulse_start();
        send(16'h5555, 1'b0);
        pulse_start();
        #1;
        chk("t5_count_kept", word_count, 1);
        chk("t5_still_busy", {30'd0, busy, in_ready}, 32'h3);
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        #1;
        chk("t5_abort", {in_ready, cpu_hold, busy, done, error}, 0);
        chk("t5_nwr", nwr - base, 2);

        // test 6: start and abort together from DONE
        pulse_start();
        send(16'h4242, 1'b1);
        cyc(2);
        chk("t6_done_before", {31'd0, done}, 1);
        base = nwr;
        @(negedge clock);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clock);
        start = 1'b0;
        abort = 1'b0;
        cyc(3);
        chk("t6_idle", {in_ready, cpu_hold, busy, done, error}, 0);
        chk("t6_no_write", nwr - base, 0);
        chk("final_no_bad_write", bad, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
